// File: rtl/ppu_mode_sequencer_if.sv
// ppu_mode_sequencer_if
//   Bundles the sequencer's control inputs and timing/status outputs.
//   master : the sequencer (drives timing, pulses, status)
//   slave  : the PPU side (drives lcd_en, lyc, stat_sel, fetch_done)
//   Signals: lcd_en, lyc, stat_sel, fetch_done, mode2_start, mode3_start,
//            mode, ly, dot, lyc_match, stat_irq, vblank_irq, frame_done,
//            mode3_len, mode3_timeout
interface ppu_mode_sequencer_if #(
  parameter int LY_W  = 8,
  parameter int DOT_W = 9
);
  logic             lcd_en;
  logic [LY_W-1:0]  lyc;
  logic [3:0]       stat_sel;
  logic             fetch_done;
  logic             mode2_start;
  logic             mode3_start;
  logic [1:0]       mode;
  logic [LY_W-1:0]  ly;
  logic [DOT_W-1:0] dot;
  logic             lyc_match;
  logic             stat_irq;
  logic             vblank_irq;
  logic             frame_done;
  logic [DOT_W-1:0] mode3_len;
  logic             mode3_timeout;

  modport master (
    input  lcd_en, lyc, stat_sel, fetch_done,
    output mode2_start, mode3_start, mode, ly, dot, lyc_match,
           stat_irq, vblank_irq, frame_done, mode3_len, mode3_timeout
  );

  modport slave (
    output lcd_en, lyc, stat_sel, fetch_done,
    input  mode2_start, mode3_start, mode, ly, dot, lyc_match,
           stat_irq, vblank_irq, frame_done, mode3_len, mode3_timeout
  );
endinterface

// File: rtl/ppu_mode_sequencer.sv
// ppu_mode_sequencer
//   LCD timing and mode sequencer: dot counter, scanline counter, the
//   2->3->0 mode sequence on visible lines and mode 1 during vblank, start
//   pulses for the OAM-search and pixel-fetch engines, and edge-detected
//   STAT / VBLANK interrupts.
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset
//     bus  : ppu_mode_sequencer_if.master (control inputs, timing outputs)
//   Optional build macro:
//     PPU_LINE153_QUIRK_EN - on the last vblank line, from dot 4 onward, ly
//     (and the LYC compare) reads 0; internal line count is unchanged.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | lcd_en low; counters held at 0, no pulses
//   M2    | OAM search, fixed OAM_DOTS clocks
//   M3    | pixel transfer, ends on fetch_done or timeout
//   M0    | hblank, until end of line
//   M1    | vblank lines
module ppu_mode_sequencer #(
  parameter int DOTS_PER_LINE = 456,
  parameter int VISIBLE_LINES = 144,
  parameter int VBLANK_LINES  = 10,
  parameter int OAM_DOTS      = 80,
  parameter int MIN_HBLANK    = 8,
  parameter int LY_W          = 8,
  parameter int DOT_W         = 9
) (
  input  logic clk,
  input  logic rst,
  ppu_mode_sequencer_if.master bus
);

  localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0] OAM_LAST  = DOT_W'(OAM_DOTS - 1);
  localparam logic [DOT_W-1:0] M3_LAST   = DOT_W'(DOTS_PER_LINE - MIN_HBLANK - 1);
  localparam logic [LY_W-1:0]  LINE_LAST = LY_W'(VISIBLE_LINES + VBLANK_LINES - 1);
  localparam logic [LY_W-1:0]  VIS_LINES = LY_W'(VISIBLE_LINES);

  typedef enum logic [2:0] {S_IDLE, S_M2, S_M3, S_M0, S_M1} state_t;

  state_t           state_q, state_d;
  logic [DOT_W-1:0] dot_q, dot_d;
  logic [LY_W-1:0]  line_q, line_d;
  logic [1:0]       mode_q, mode_d;
  logic             m2_start_q, m2_start_d;
  logic             m3_start_q, m3_start_d;
  logic             vblank_q, vblank_d;
  logic             frame_q, frame_d;
  logic [DOT_W-1:0] m3_len_q, m3_len_d;
  logic             timeout_q, timeout_d;
  logic             stat_line, stat_line_q;
  logic             line_wrap, frame_wrap;
  logic [LY_W-1:0]  ly_rep;
  logic             lyc_hit;

  assign line_wrap  = (dot_q == DOT_LAST);
  assign frame_wrap = line_wrap && (line_q == LINE_LAST);

  always_comb begin
    state_d    = state_q;
    dot_d      = dot_q;
    line_d     = line_q;
    m2_start_d = 1'b0;
    m3_start_d = 1'b0;
    vblank_d   = 1'b0;
    frame_d    = 1'b0;
    m3_len_d   = m3_len_q;
    timeout_d  = timeout_q;

    if (!bus.lcd_en) begin
      state_d = S_IDLE;
      dot_d   = '0;
      line_d  = '0;
    end else if (state_q == S_IDLE) begin
      state_d    = S_M2;
      dot_d      = '0;
      line_d     = '0;
      m2_start_d = 1'b1;
    end else begin
      dot_d = line_wrap ? '0 : dot_q + DOT_W'(1);
      if (line_wrap) line_d = frame_wrap ? '0 : line_q + LY_W'(1);

      case (state_q)
        S_M2: begin
          if (dot_q == OAM_LAST) begin
            state_d    = S_M3;
            m3_start_d = 1'b1;
          end
        end
        S_M3: begin
          // M3 started at dot OAM_DOTS, so its length including this cycle
          // is dot - (OAM_DOTS - 1).
          if (bus.fetch_done) begin
            state_d  = S_M0;
            m3_len_d = dot_q - OAM_LAST;
          end else if (dot_q == M3_LAST) begin
            state_d   = S_M0;
            m3_len_d  = dot_q - OAM_LAST;
            timeout_d = 1'b1;
          end
        end
        S_M0: begin
          if (line_wrap) begin
            if (line_d < VIS_LINES) begin
              state_d    = S_M2;
              m2_start_d = 1'b1;
            end else begin
              state_d  = S_M1;
              vblank_d = 1'b1;
            end
          end
        end
        S_M1: begin
          if (frame_wrap) begin
            state_d    = S_M2;
            m2_start_d = 1'b1;
            frame_d    = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_M2:    mode_d = 2'd2;
      S_M3:    mode_d = 2'd3;
      S_M1:    mode_d = 2'd1;
      default: mode_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dot_q       <= '0;
      line_q      <= '0;
      mode_q      <= 2'd0;
      m2_start_q  <= 1'b0;
      m3_start_q  <= 1'b0;
      vblank_q    <= 1'b0;
      frame_q     <= 1'b0;
      m3_len_q    <= '0;
      timeout_q   <= 1'b0;
      stat_line_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dot_q       <= dot_d;
      line_q      <= line_d;
      mode_q      <= mode_d;
      m2_start_q  <= m2_start_d;
      m3_start_q  <= m3_start_d;
      vblank_q    <= vblank_d;
      frame_q     <= frame_d;
      m3_len_q    <= m3_len_d;
      timeout_q   <= timeout_d;
      stat_line_q <= stat_line;
    end
  end

`ifdef PPU_LINE153_QUIRK_EN
  localparam logic [DOT_W-1:0] QUIRK_DOT = DOT_W'(4);
  assign ly_rep = (line_q == LINE_LAST && dot_q >= QUIRK_DOT) ? '0 : line_q;
`else
  assign ly_rep = line_q;
`endif

  assign lyc_hit = (ly_rep == bus.lyc);

  // Single OR'd STAT line; only its rising edge interrupts, so a source
  // handing over to another enabled source produces no second pulse.
  assign stat_line = (state_q != S_IDLE) &&
                     ((lyc_hit && bus.stat_sel[3]) ||
                      (mode_q == 2'd2 && bus.stat_sel[2]) ||
                      (mode_q == 2'd1 && bus.stat_sel[1]) ||
                      (mode_q == 2'd0 && bus.stat_sel[0]));

  assign bus.stat_irq      = stat_line && !stat_line_q;
  assign bus.lyc_match     = lyc_hit;
  assign bus.ly            = ly_rep;
  assign bus.dot           = dot_q;
  assign bus.mode          = mode_q;
  assign bus.mode2_start   = m2_start_q;
  assign bus.mode3_start   = m3_start_q;
  assign bus.vblank_irq    = vblank_q;
  assign bus.frame_done    = frame_q;
  assign bus.mode3_len     = m3_len_q;
  assign bus.mode3_timeout = timeout_q;

endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// tb_ppu_mode_sequencer
//   Four default-parameter sequencers share one clock and run one full
//   frame in parallel, each with its own stimulus:
//     a : fetch_done at dot 251, stat_sel=0011, lyc=10  (normal timing)
//     b : fetch_done never,      stat_sel=1000, lyc=10  (timeout, LYC irq)
//     c : fetch_done at dot 251, stat_sel=1000, lyc=0   (line-153 behaviour)
//     d : fetch_done always 1,   stat_sel=0100, lyc=0   (lcd_en drop/restart)
//   t counts cycles from the first M2 cycle after enable; samples at negedge.
module tb_ppu_mode_sequencer;

  localparam int DPL    = 456;
  localparam int LINES  = 154;
  localparam int FRAME  = DPL * LINES;     // 70224
  localparam int T_END  = FRAME + 16;
  localparam int T_DROP = 50 * DPL + 80;   // d: ly 50, first M3 cycle

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppu_mode_sequencer_if #(.LY_W(8), .DOT_W(9)) bus_a ();
  ppu_mode_sequencer_if #(.LY_W(8), .DOT_W(9)) bus_b ();
  ppu_mode_sequencer_if #(.LY_W(8), .DOT_W(9)) bus_c ();
  ppu_mode_sequencer_if #(.LY_W(8), .DOT_W(9)) bus_d ();

  ppu_mode_sequencer u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  ppu_mode_sequencer u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));
  ppu_mode_sequencer u_dut_c (.clk(clk), .rst(rst), .bus(bus_c.master));
  ppu_mode_sequencer u_dut_d (.clk(clk), .rst(rst), .bus(bus_d.master));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_mode_a(input int ln, input int dt);
    if (ln >= 144)     return 2'd1;
    else if (dt < 80)  return 2'd2;
    else if (dt < 252) return 2'd3;
    else               return 2'd0;
  endfunction

  int a_mode_bad = 0, a_ly_bad = 0, a_dot_bad = 0;
  int a_m2s = 0, a_m3s = 0, a_vbl = 0, a_vbl_t = -1, a_frm = 0, a_frm_t = -1;
  int a_stat = 0, a_stat_vb = 0;
  int b_stat = 0, b_stat_t = -1, b_lyc = 0;
  int c_stat = 0;

  initial begin
    rst = 1'b1;
    bus_a.lcd_en = 1'b0; bus_a.lyc = 8'd10; bus_a.stat_sel = 4'b0011; bus_a.fetch_done = 1'b0;
    bus_b.lcd_en = 1'b0; bus_b.lyc = 8'd10; bus_b.stat_sel = 4'b1000; bus_b.fetch_done = 1'b0;
    bus_c.lcd_en = 1'b0; bus_c.lyc = 8'd0;  bus_c.stat_sel = 4'b1000; bus_c.fetch_done = 1'b0;
    bus_d.lcd_en = 1'b0; bus_d.lyc = 8'd0;  bus_d.stat_sel = 4'b0100; bus_d.fetch_done = 1'b1;
    repeat (3) @(negedge clk);

    check_val("rst_dot",       bus_a.dot,           0);
    check_val("rst_ly",        bus_a.ly,            0);
    check_val("rst_mode",      bus_a.mode,          0);
    check_val("rst_m2start",   bus_a.mode2_start,   0);
    check_val("rst_m3start",   bus_a.mode3_start,   0);
    check_val("rst_stat_irq",  bus_a.stat_irq,      0);
    check_val("rst_vblank",    bus_a.vblank_irq,    0);
    check_val("rst_frame",     bus_a.frame_done,    0);
    check_val("rst_m3len",     bus_a.mode3_len,     0);
    check_val("rst_timeout",   bus_a.mode3_timeout, 0);

    // rst held while lcd_en rises: reset must win
    bus_a.lcd_en = 1'b1; bus_b.lcd_en = 1'b1; bus_c.lcd_en = 1'b1; bus_d.lcd_en = 1'b1;
    @(negedge clk);
    check_val("rstwin_mode",    bus_a.mode,        0);
    check_val("rstwin_m2start", bus_a.mode2_start, 0);
    rst = 1'b0;

    for (int t = 0; t <= T_END; t++) begin
      int ln, dt;
      @(negedge clk);
      ln = (t / DPL) % LINES;
      dt = t % DPL;

      if (bus_a.mode != exp_mode_a(ln, dt)) a_mode_bad++;
      if (bus_a.ly  != 8'(ln)) a_ly_bad++;
      if (bus_a.dot != 9'(dt)) a_dot_bad++;
      if (t < FRAME) begin
        if (bus_a.mode2_start) a_m2s++;
        if (bus_a.mode3_start) a_m3s++;
        if (bus_a.stat_irq) begin
          a_stat++;
          if (ln >= 144) a_stat_vb++;
        end
        if (bus_b.stat_irq) begin
          b_stat++;
          b_stat_t = t;
        end
        if (bus_b.lyc_match) b_lyc++;
      end
      if (bus_a.vblank_irq) begin a_vbl++; a_vbl_t = t; end
      if (bus_a.frame_done) begin a_frm++; a_frm_t = t; end
      if (bus_c.stat_irq) c_stat++;

      if (t == 0) begin
        check_val("a_t0_m2start", bus_a.mode2_start, 1);
        check_val("a_t0_mode",    bus_a.mode,        2);
      end
      if (t == 79)  check_val("a_dot79_mode", bus_a.mode, 2);
      if (t == 80) begin
        check_val("a_dot80_mode",    bus_a.mode,        3);
        check_val("a_dot80_m3start", bus_a.mode3_start, 1);
        check_val("d_dot80_mode",    bus_d.mode,        3);
      end
      if (t == 251) check_val("a_dot251_mode", bus_a.mode, 3);
      if (t == 252) check_val("a_dot252_mode", bus_a.mode, 0);
      if (t == 260) check_val("a_m3len",       bus_a.mode3_len, 172);
      if (t == 456) begin
        check_val("a_l1_m2start", bus_a.mode2_start, 1);
        check_val("a_l1_ly",      bus_a.ly,          1);
        check_val("a_l1_dot",     bus_a.dot,         0);
      end
      if (t == 65664) check_val("a_vbl_mode", bus_a.mode, 1);

      if (t == 447) begin
        check_val("b_dot447_mode",    bus_b.mode,          3);
        check_val("b_dot447_timeout", bus_b.mode3_timeout, 0);
      end
      if (t == 448) begin
        check_val("b_dot448_mode",    bus_b.mode,          0);
        check_val("b_dot448_timeout", bus_b.mode3_timeout, 1);
        check_val("b_m3len",          bus_b.mode3_len,     368);
      end
      if (t == T_END) check_val("b_timeout_sticky", bus_b.mode3_timeout, 1);

      if (t == 50) check_val("d_fetch_in_m2", bus_d.mode, 2);
      if (t == 81) begin
        check_val("d_m3_one_clk", bus_d.mode,      0);
        check_val("d_m3len",      bus_d.mode3_len, 1);
      end
      if (t == T_DROP) begin
        check_val("d_predrop_mode", bus_d.mode, 3);
        check_val("d_predrop_ly",   bus_d.ly,   50);
      end
      if (t == T_DROP + 1) begin
        check_val("d_drop_mode",    bus_d.mode,        0);
        check_val("d_drop_ly",      bus_d.ly,          0);
        check_val("d_drop_dot",     bus_d.dot,         0);
        check_val("d_drop_m2start", bus_d.mode2_start, 0);
        check_val("d_drop_m3start", bus_d.mode3_start, 0);
        check_val("d_drop_stat",    bus_d.stat_irq,    0);
      end
      if (t == T_DROP + 4) begin
        check_val("d_idle_mode",    bus_d.mode,        0);
        check_val("d_idle_m2start", bus_d.mode2_start, 0);
      end
      if (t == T_DROP + 5) begin
        check_val("d_re_m2start", bus_d.mode2_start, 1);
        check_val("d_re_mode",    bus_d.mode,        2);
        check_val("d_re_ly",      bus_d.ly,          0);
        check_val("d_re_dot",     bus_d.dot,         0);
        check_val("d_re_stat",    bus_d.stat_irq,    1);
      end
      if (t == T_DROP + 6) begin
        check_val("d_re_dot1",       bus_d.dot,         1);
        check_val("d_re_m2start_lo", bus_d.mode2_start, 0);
      end

      if (t == 69771) check_val("c_ly_dot3", bus_c.ly, 153);
`ifdef PPU_LINE153_QUIRK_EN
      if (t == 69772) begin
        check_val("c_quirk_ly",   bus_c.ly,       0);
        check_val("c_quirk_stat", bus_c.stat_irq, 1);
      end
      if (t == FRAME - 1) check_val("c_quirk_ly_end", bus_c.ly, 0);
      if (t == FRAME) check_val("c_wrap_stat", bus_c.stat_irq, 0);
`else
      if (t == 69772) begin
        check_val("c_ly_dot4",   bus_c.ly,       153);
        check_val("c_stat_dot4", bus_c.stat_irq, 0);
      end
      if (t == FRAME - 1) check_val("c_ly_end", bus_c.ly, 153);
      if (t == FRAME) check_val("c_wrap_stat", bus_c.stat_irq, 1);
`endif
      if (t == FRAME) check_val("c_frame_done", bus_c.frame_done, 1);

      // inputs for the edge that ends this cycle
      bus_a.fetch_done = (dt == 251) && (ln < 144);
      bus_c.fetch_done = (dt == 251) && (ln < 144);
      if (t == T_DROP)     bus_d.lcd_en = 1'b0;
      if (t == T_DROP + 4) bus_d.lcd_en = 1'b1;
    end

    check_val("a_mode_seq_errs", a_mode_bad, 0);
    check_val("a_ly_seq_errs",   a_ly_bad,   0);
    check_val("a_dot_seq_errs",  a_dot_bad,  0);
    check_val("a_m2start_cnt",   a_m2s,      144);
    check_val("a_m3start_cnt",   a_m3s,      144);
    check_val("a_vblank_cnt",    a_vbl,      1);
    check_val("a_vblank_t",      a_vbl_t,    144 * DPL);
    check_val("a_frame_cnt",     a_frm,      1);
    check_val("a_frame_t",       a_frm_t,    FRAME);
    check_val("a_stat_cnt",      a_stat,     144);
    check_val("a_stat_vblank",   a_stat_vb,  0);
    check_val("b_stat_cnt",      b_stat,     1);
    check_val("b_stat_t",        b_stat_t,   10 * DPL);
    check_val("b_lyc_clks",      b_lyc,      DPL);
    check_val("c_stat_cnt",      c_stat,     2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
